// File: rtl/systolic_feeder.sv
// systolic_feeder: tile sequencer and input skew generator for the systolic MAC array.
// It takes one tile's weight rows (w_*) and then num_vecs activation vectors (a_*)
// over valid/ready streams, and drives the array controls and input buses.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, num_vecs              tile request and activation-vector count (K)
//   w_valid/w_ready/w_data       weight-row stream, ARRAY_SIZE lanes
//   a_valid/a_ready/a_data       activation-vector stream, ARRAY_SIZE lanes
//   enable, load_weights,
//   clear_acc, acc_enable        array controls (registered)
//   weight_inputs_flat           weight row to the array (registered)
//   input_activations_flat       skewed activations, lane i delayed i advances
//   busy, done                   tile in flight / one-cycle completion pulse

// One skew lane: a DEPTH-deep shift register that moves only when adv is high.
module systolic_feeder_lane #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  adv,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (adv) begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

module systolic_feeder #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             num_vecs,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_data,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_data,
  output logic                             enable,
  output logic                             load_weights,
  output logic                             clear_acc,
  output logic                             acc_enable,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weight_inputs_flat,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] input_activations_flat,
  output logic                             busy,
  output logic                             done
);
  localparam int RW = $clog2(ARRAY_SIZE) + 1;
  localparam int DW = $clog2(2*ARRAY_SIZE);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ARRAY_SIZE-1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2*ARRAY_SIZE-2);

  typedef enum logic [2:0] {IDLE, LOAD_W, CLEAR, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [RW-1:0]        row_cnt;
  logic [CNT_WIDTH-1:0] vec_cnt, k_reg;
  logic [DW-1:0]        drain_cnt;
  logic go, w_acc, a_acc, adv, line_clr;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] inj;

  assign go       = (state == IDLE) && start && (num_vecs != '0);
  assign w_ready  = (state == LOAD_W);
  assign a_ready  = (state == STREAM);
  assign w_acc    = w_ready && w_valid;
  assign a_acc    = a_ready && a_valid;
  // DRAIN pushes zeros through so the last vector reaches every lane.
  assign adv      = a_acc || (state == DRAIN);
  assign inj      = a_acc ? a_data : '0;
  // Clearing on DONE as well keeps the bus at zero while idle.
  assign line_clr = go || (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = LOAD_W;
      LOAD_W:  if (w_acc && row_cnt == ROW_LAST) state_nx = CLEAR;
      CLEAR:   state_nx = STREAM;
      STREAM:  if (a_acc && vec_cnt == k_reg - CNT_WIDTH'(1)) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt   <= '0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
      k_reg     <= '0;
    end else begin
      if (go) begin
        k_reg     <= num_vecs;
        row_cnt   <= '0;
        vec_cnt   <= '0;
        drain_cnt <= '0;
      end
      if (w_acc)          row_cnt   <= row_cnt + RW'(1);
      if (a_acc)          vec_cnt   <= vec_cnt + CNT_WIDTH'(1);
      if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
    end
  end

  // Controls reflect the state / handshake seen at the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable             <= 1'b0;
      load_weights       <= 1'b0;
      clear_acc          <= 1'b0;
      acc_enable         <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      weight_inputs_flat <= '0;
    end else begin
      enable       <= adv;
      load_weights <= w_acc;
      clear_acc    <= (state == CLEAR);
      acc_enable   <= (state == STREAM) || (state == DRAIN);
      busy         <= go || (state inside {LOAD_W, CLEAR, STREAM, DRAIN});
      done         <= (state == DONE);
      if (w_acc) weight_inputs_flat <= w_data;
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    systolic_feeder_lane #(.DEPTH(i+1), .DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (line_clr),
      .adv  (adv),
      .din  (inj[i*DATA_WIDTH +: DATA_WIDTH]),
      .dout (input_activations_flat[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int BW = N*DW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [CW-1:0] num_vecs = '0;
  logic w_valid = 1'b0, a_valid = 1'b0;
  logic [BW-1:0] w_data = '0, a_data = '0;
  logic w_ready, a_ready, enable, load_weights, clear_acc, acc_enable, busy, done;
  logic [BW-1:0] weight_inputs_flat, input_activations_flat;

  int total = 0;
  int bad   = 0;

  systolic_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .enable(enable), .load_weights(load_weights), .clear_acc(clear_acc),
    .acc_enable(acc_enable), .weight_inputs_flat(weight_inputs_flat),
    .input_activations_flat(input_activations_flat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    int k; int w_at; int w_n; int a_at; int a_n; bit bstart; int exp_lat;
  } tile_t;

  // Runs one tile; must be called at a negedge. Expected activations come from
  // the diagonal rule: at the n-th enabled cycle lane i carries vector n-i.
  task automatic run_tile(input int k, input int w_at, input int w_n, input int a_at,
                          input int a_n, input bit bstart, input int exp_lat);
    logic [BW-1:0] wq [N];
    logic [BW-1:0] av [$];
    logic [BW-1:0] prev, expv, v;
    int wi = 0, ai = 0, ws = w_n, as_ = a_n;
    int lw_n = 0, clr_n = 0, en_n = 0, acc_n = 0, busy_n = 0, cyc = 0, lat = -1;
    prev = '0;
    for (int r = 0; r < N; r++) wq[r] = {$urandom(), $urandom()};
    for (int m = 0; m < k; m++) av.push_back({$urandom(), $urandom()});
    start = 1'b1; num_vecs = CW'(k); w_valid = 1'b0; a_valid = 1'b0;
    @(posedge clk);
    while (lat < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (load_weights) begin
        if (lw_n < N) check("wrow", weight_inputs_flat, wq[lw_n]);
        lw_n++;
      end
      if (clear_acc) begin
        clr_n++;
        check("clr_after_rows", lw_n, N);
      end
      if (enable) begin
        expv = '0;
        for (int i = 0; i < N; i++) begin
          int m;
          m = en_n - i;
          if (m >= 0 && m < k) begin
            v = av[m];
            expv[i*DW +: DW] = v[i*DW +: DW];
          end
        end
        check("diag", input_activations_flat, expv);
        en_n++;
      end else if (acc_enable) begin
        check("freeze", input_activations_flat, prev);
      end
      prev = input_activations_flat;
      if (acc_enable) acc_n++;
      if (busy) busy_n++;
      if (done) begin
        lat = cyc - 1;
        check("done_busy_low", busy, 0);
      end
      start    = bstart && (cyc == 3);
      num_vecs = start ? CW'(9) : CW'(k);
      if (w_ready && wi < N) begin
        if (wi == w_at && ws > 0) begin w_valid = 1'b0; ws--; end
        else begin w_valid = 1'b1; w_data = wq[wi]; wi++; end
      end else begin
        w_valid = 1'($urandom % 2); w_data = {$urandom(), $urandom()};
      end
      if (a_ready && ai < k) begin
        if (ai == a_at && as_ > 0) begin a_valid = 1'b0; as_--; end
        else begin a_valid = 1'b1; a_data = av[ai]; ai++; end
      end else begin
        a_valid = 1'($urandom % 2); a_data = {$urandom(), $urandom()};
      end
    end
    check("done_seen", lat >= 0, 1);
    check("latency", lat, exp_lat);
    check("rows", lw_n, N);
    check("clear_cnt", clr_n, 1);
    check("enable_cnt", en_n, k + 2*N - 1);
    check("acc_en_cnt", acc_n, k + a_n + 2*N - 1);
    check("busy_cnt", busy_n, lat);
    check("flat_idle", input_activations_flat, 0);
  endtask

  initial begin
    tile_t tbl [6];
    int dcnt;
    tbl[0] = '{3, 0, 0, 0, 0, 1'b0, 16};
    tbl[1] = '{3, 0, 0, 1, 2, 1'b0, 18};
    tbl[2] = '{3, 1, 3, 0, 0, 1'b0, 19};
    tbl[3] = '{1, 0, 0, 0, 0, 1'b0, 14};
    tbl[4] = '{3, 0, 0, 0, 0, 1'b1, 16};
    tbl[5] = '{6, 3, 1, 5, 2, 1'b0, 22};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ctrl", {enable, load_weights, clear_acc, acc_enable}, 0);
    check("rst_ready", {w_ready, a_ready}, 0);
    check("rst_wflat", weight_inputs_flat, 0);
    check("rst_aflat", input_activations_flat, 0);
    rst_n = 1'b1;

    // start with K=0 is ignored
    @(negedge clk);
    start = 1'b1; num_vecs = '0;
    repeat (3) begin
      @(negedge clk);
      check("k0_busy", busy, 0);
      check("k0_wready", w_ready, 0);
    end
    start = 1'b0;

    // table tiles, issued back-to-back
    @(negedge clk);
    for (int t = 0; t < 6; t++)
      run_tile(tbl[t].k, tbl[t].w_at, tbl[t].w_n, tbl[t].a_at, tbl[t].a_n,
               tbl[t].bstart, tbl[t].exp_lat);
    start = 1'b0;

    // reset in the middle of DRAIN
    @(negedge clk);
    start = 1'b1; num_vecs = CW'(2); w_valid = 1'b1; a_valid = 1'b1;
    w_data = {$urandom(), $urandom()}; a_data = {$urandom(), $urandom()};
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_acc", acc_enable, 1);
    check("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ctrl", {enable, load_weights, clear_acc, acc_enable, busy, done}, 0);
    check("arst_ready", {w_ready, a_ready}, 0);
    check("arst_aflat", input_activations_flat, 0);
    check("arst_wflat", weight_inputs_flat, 0);
    @(negedge clk);
    rst_n = 1'b1; w_valid = 1'b0; a_valid = 1'b0;
    dcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("no_done_after_abort", dcnt, 0);

    // randomized tiles against the latency/diagonal model
    @(negedge clk);
    for (int t = 0; t < 8; t++) begin
      int k, wa, wn, aa, an;
      bit bs;
      k  = $urandom_range(1, 10);
      wa = $urandom_range(0, N-1);
      wn = $urandom_range(0, 3);
      aa = $urandom_range(0, k-1);
      an = $urandom_range(0, 3);
      bs = 1'($urandom % 2);
      run_tile(k, wa, wn, aa, an, bs, 3*N + k + 1 + wn + an);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
